// File: rtl/brownout_margin_ctrl.sv
// Brown-out / under-voltage detector sequencer: settles the analog block, scans vtrip
// codes 0..7 for supply margin, then programs a guarded threshold and monitors for events.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | detector off, waiting for start
// SETTLE   | ena high, waiting for bias/bandgap to settle
// STEP     | vtrip just changed, waiting for the comparator to follow
// SAMPLE   | accumulating vunder over the sample window for this code
// DONE     | publish margin, program guarded vtrip (one cycle)
// MONITOR  | detector running at guarded vtrip, edge-detecting events
module brownout_margin_ctrl #(
  parameter int SETTLE_CYC = 64,
  parameter int STEP_CYC   = 16,
  parameter int SAMPLES    = 4,
  parameter int GUARD      = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic [2:0] cfg_otrip,
  input  logic       vunder_async,
  input  logic       out_async,
  output logic       ena,
  output logic [2:0] vtrip,
  output logic [2:0] otrip,
  output logic       force_ena_rc_osc,
  output logic       busy,
  output logic [3:0] margin_code,
  output logic       margin_valid,
  output logic       scan_fail,
  output logic       irq_vunder,
  output logic       irq_brownout
);

  localparam int CNT_MAX = (SETTLE_CYC > STEP_CYC) ? SETTLE_CYC : STEP_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_STEP, S_SAMPLE, S_DONE, S_MONITOR
  } state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [3:0]        scnt;
  logic [2:0]        code;
  logic              fail_flag;
  logic              vu_s1, vu_s, bo_s1, bo_s;
  logic              vu_d, bo_d;
  logic signed [4:0] guard_diff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vu_s1 <= 1'b0;
      vu_s  <= 1'b0;
      bo_s1 <= 1'b0;
      bo_s  <= 1'b0;
    end else begin
      vu_s1 <= vunder_async;
      vu_s  <= vu_s1;
      bo_s1 <= out_async;
      bo_s  <= bo_s1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) otrip <= 3'd0;
    else     otrip <= ena ? cfg_otrip : 3'd0;
  end

  // Signed so a small margin saturates the monitor threshold at code 0.
  assign guard_diff = $signed({1'b0, margin_code}) - $signed(5'd1) - $signed(5'(GUARD));
  assign busy = (state == S_SETTLE) || (state == S_STEP) || (state == S_SAMPLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= S_IDLE;
      cnt              <= '0;
      scnt             <= 4'd0;
      code             <= 3'd0;
      fail_flag        <= 1'b0;
      vu_d             <= 1'b0;
      bo_d             <= 1'b0;
      ena              <= 1'b0;
      vtrip            <= 3'd0;
      force_ena_rc_osc <= 1'b0;
      margin_code      <= 4'd0;
      margin_valid     <= 1'b0;
      scan_fail        <= 1'b0;
      irq_vunder       <= 1'b0;
      irq_brownout     <= 1'b0;
    end else begin
      irq_vunder   <= 1'b0;
      irq_brownout <= 1'b0;
      if (stop) begin
        state            <= S_IDLE;
        cnt              <= '0;
        scnt             <= 4'd0;
        code             <= 3'd0;
        fail_flag        <= 1'b0;
        ena              <= 1'b0;
        vtrip            <= 3'd0;
        force_ena_rc_osc <= 1'b0;
        margin_code      <= 4'd0;
        margin_valid     <= 1'b0;
        scan_fail        <= 1'b0;
      end else if (start) begin
        // Restart keeps ena high so the detector bias is never interrupted.
        state            <= S_SETTLE;
        cnt              <= CW'(SETTLE_CYC - 1);
        code             <= 3'd0;
        ena              <= 1'b1;
        vtrip            <= 3'd0;
        force_ena_rc_osc <= 1'b1;
        margin_valid     <= 1'b0;
        scan_fail        <= 1'b0;
      end else begin
        case (state)
          S_SETTLE: begin
            if (cnt == '0) begin
              state <= S_STEP;
              code  <= 3'd0;
              vtrip <= 3'd0;
              cnt   <= CW'(STEP_CYC - 1);
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          S_STEP: begin
            if (cnt == '0) begin
              state     <= S_SAMPLE;
              fail_flag <= 1'b0;
              scnt      <= 4'(SAMPLES - 1);
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          S_SAMPLE: begin
            if (scnt == 4'd0) begin
              if (fail_flag || vu_s) begin
                margin_code <= {1'b0, code};
                state       <= S_DONE;
              end else if (code == 3'd7) begin
                margin_code <= 4'd8;
                state       <= S_DONE;
              end else begin
                code  <= code + 3'd1;
                vtrip <= code + 3'd1;
                cnt   <= CW'(STEP_CYC - 1);
                state <= S_STEP;
              end
            end else begin
              fail_flag <= fail_flag | vu_s;
              scnt      <= scnt - 4'd1;
            end
          end
          S_DONE: begin
            margin_valid     <= 1'b1;
            scan_fail        <= (margin_code == 4'd0);
            vtrip            <= (guard_diff < 0) ? 3'd0 : guard_diff[2:0];
            force_ena_rc_osc <= 1'b0;
            // Preload so a level already high on entry is not reported as an edge.
            vu_d             <= vu_s;
            bo_d             <= bo_s;
            state            <= S_MONITOR;
          end
          S_MONITOR: begin
            irq_vunder   <= vu_s & ~vu_d;
            irq_brownout <= bo_s & ~bo_d;
            vu_d         <= vu_s;
            bo_d         <= bo_s;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_brownout_margin_ctrl.sv
// Scoreboard bench for brownout_margin_ctrl: a detector model drives vunder from vtrip,
// expected scan results are queued at start and checked when margin_valid rises.
module tb_brownout_margin_ctrl;
  localparam int S  = 64;
  localparam int ST = 16;
  localparam int SM = 4;
  localparam int G  = 1;
  localparam int P  = ST + SM;

  logic        clk = 1'b0;
  logic        rst, start, stop;
  logic [2:0]  cfg_otrip;
  logic        vunder_async, out_async;
  logic        ena, force_ena_rc_osc, busy, margin_valid, scan_fail, irq_vunder, irq_brownout;
  logic [2:0]  vtrip, otrip;
  logic [3:0]  margin_code;
  logic [16:0] outs;

  brownout_margin_ctrl #(.SETTLE_CYC(S), .STEP_CYC(ST), .SAMPLES(SM), .GUARD(G)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .cfg_otrip(cfg_otrip),
    .vunder_async(vunder_async), .out_async(out_async), .ena(ena), .vtrip(vtrip),
    .otrip(otrip), .force_ena_rc_osc(force_ena_rc_osc), .busy(busy),
    .margin_code(margin_code), .margin_valid(margin_valid), .scan_fail(scan_fail),
    .irq_vunder(irq_vunder), .irq_brownout(irq_brownout)
  );

  always #5 clk = ~clk;

  assign outs = {ena, vtrip, otrip, force_ena_rc_osc, busy, margin_code, margin_valid,
                 scan_fail, irq_vunder, irq_brownout};

  // Detector model: supply is below threshold whenever vtrip >= th, plus injected glitches.
  int   th = 8;
  logic glitch = 1'b0;
  logic env_on = 1'b1;
  logic vu_manual = 1'b0;
  assign vunder_async = env_on ? ((int'(vtrip) >= th) || glitch) : vu_manual;

  typedef struct {
    int mc;
    int vt;
    int sf;
    int st_cyc;
    int lat;
    int brun;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   vu_cnt = 0;
  int   bo_cnt = 0;
  int   vu_last_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Margin = first code whose sample window sees vunder; 8 if none do.
  function automatic exp_t model(input int thr, input int gfail);
    exp_t e;
    int m;
    m = 8;
    for (int c = 7; c >= 0; c--)
      if (c >= thr || c == gfail) m = c;
    e.mc     = m;
    e.vt     = (m - 1 - G < 0) ? 0 : m - 1 - G;
    e.sf     = (m == 0) ? 1 : 0;
    e.lat    = S + ((m == 8) ? 8 : m + 1) * P + 1;
    e.brun   = e.lat - 1;
    e.st_cyc = 0;
    return e;
  endfunction

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    int i;
    i = 0;
    while (sb.size() != 0 && i < 400) begin
      @(posedge clk);
      #2;
      i++;
    end
    chk("scan_done_in_budget", sb.size(), 0);
    sb.delete();
  endtask

  // gmode: 0 none, 1 glitch inside SAMPLE window of code g, 2 glitch inside STEP of code g
  task automatic run_scan(input int thr, input int gmode, input int g, input int o);
    exp_t e;
    th        = thr;
    cfg_otrip = 3'($urandom_range(0, 7));
    e = model(thr, (gmode == 1) ? g : -1);
    do_start();
    e.st_cyc = cyc;
    sb.push_back(e);
    chk("ena_after_start", int'(ena), 1);
    chk("force_osc_after_start", int'(force_ena_rc_osc), 1);
    if (gmode == 1) begin
      tick(S + g * P + ST - 1 + o - 1);
      glitch = 1'b1;
      tick(1);
      glitch = 1'b0;
    end else if (gmode == 2) begin
      tick(S + g * P + o - 1);
      glitch = 1'b1;
      tick(1);
      glitch = 1'b0;
    end
    wait_done();
    tick(3);
    chk("otrip_in_monitor", int'(otrip), int'(cfg_otrip));
    chk("ena_in_monitor", int'(ena), 1);
  endtask

  // Monitor: pops the scoreboard on each margin_valid rise and polices the IRQs.
  initial begin
    logic mv_p, ivu_p, ibo_p;
    int   brun, last_brun;
    exp_t e;
    mv_p = 1'b0; ivu_p = 1'b0; ibo_p = 1'b0;
    brun = 0; last_brun = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        brun = 0;
      end else begin
        if (busy) brun++;
        else begin
          if (brun != 0) last_brun = brun;
          brun = 0;
        end
        if (margin_valid && !mv_p) begin
          if (sb.size() == 0) chk("unexpected_valid", int'(margin_valid), 0);
          else begin
            e = sb.pop_front();
            chk("margin_code", int'(margin_code), e.mc);
            chk("vtrip_guarded", int'(vtrip), e.vt);
            chk("scan_fail", int'(scan_fail), e.sf);
            chk("scan_latency", cyc - e.st_cyc, e.lat);
            chk("force_osc_off", int'(force_ena_rc_osc), 0);
            chk("busy_off", int'(busy), 0);
            if (e.brun >= 0) chk("busy_cycles", last_brun, e.brun);
          end
        end
        if (irq_vunder || irq_brownout)
          chk("irq_only_in_monitor", int'(margin_valid && ena && !busy), 1);
        if (irq_vunder) begin
          vu_cnt++;
          vu_last_cyc = cyc;
          chk("irq_vunder_width", int'(ivu_p), 0);
        end
        if (irq_brownout) begin
          bo_cnt++;
          chk("irq_brownout_width", int'(ibo_p), 0);
        end
      end
      mv_p  = margin_valid;
      ivu_p = irq_vunder;
      ibo_p = irq_brownout;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   b, t0, thr, gm, g, o;
    rst = 1'b1; start = 1'b0; stop = 1'b0; cfg_otrip = 3'd5; out_async = 1'b0;
    env_on = 1'b0;
    // Reset with inputs toggling
    for (int i = 0; i < 6; i++) begin
      vu_manual = 1'($urandom_range(0, 1));
      out_async = 1'($urandom_range(0, 1));
      start     = 1'($urandom_range(0, 1));
      stop      = 1'($urandom_range(0, 1));
      tick(1);
      chk("reset_outputs", int'(outs), 0);
    end
    start = 1'b0; stop = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      vu_manual = 1'($urandom_range(0, 1));
      out_async = 1'($urandom_range(0, 1));
      tick(1);
      chk("idle_outputs", int'(outs), 0);
    end
    vu_manual = 1'b0; out_async = 1'b0; env_on = 1'b1;
    tick(3);

    // Directed margins and boundaries
    run_scan(5, 0, 0, 0);
    run_scan(8, 0, 0, 0);
    b = vu_cnt;
    run_scan(0, 0, 0, 0);
    tick(6);
    chk("no_irq_vunder_level_on_entry", vu_cnt - b, 0);
    run_scan(8, 1, 2, 1);
    run_scan(8, 1, 2, SM - 1);
    run_scan(8, 2, 2, 5);

    // Randomized scans
    for (int n = 0; n < 8; n++) begin
      thr = $urandom_range(0, 8);
      gm  = (thr == 0) ? 0 : $urandom_range(0, 2);
      g   = (thr == 0) ? 0 : $urandom_range(0, thr - 1);
      o   = (gm == 1) ? $urandom_range(0, SM - 1) : $urandom_range(1, ST - 3);
      run_scan(thr, gm, g, o);
    end

    // MONITOR vunder edges
    run_scan(8, 0, 0, 0);
    vu_manual = 1'b0;
    env_on = 1'b0;
    tick(4);
    b  = vu_cnt;
    t0 = cyc;
    vu_manual = 1'b1;
    tick(8);
    chk("irq_vunder_one_pulse", vu_cnt - b, 1);
    chk("irq_vunder_latency_2_3", int'((vu_last_cyc - t0 >= 2) && (vu_last_cyc - t0 <= 3)), 1);
    vu_manual = 1'b0;
    tick(6);
    chk("no_irq_on_vunder_fall", vu_cnt - b, 1);
    vu_manual = 1'b1;
    tick(6);
    chk("irq_vunder_second_rise", vu_cnt - b, 2);
    vu_manual = 1'b0;
    env_on = 1'b1;

    // MONITOR brownout: high on entry, then a real rising edge
    out_async = 1'b1;
    b = bo_cnt;
    run_scan(8, 0, 0, 0);
    tick(6);
    chk("no_irq_brownout_on_entry", bo_cnt - b, 0);
    out_async = 1'b0;
    tick(5);
    out_async = 1'b1;
    tick(6);
    chk("irq_brownout_one_pulse", bo_cnt - b, 1);
    out_async = 1'b0;
    tick(3);

    // Restart from MONITOR, then restart again at code 4
    th = 8;
    do_start();
    chk("start_clears_valid", int'(margin_valid), 0);
    tick(S + 4 * P + 5);
    chk("vtrip_at_code4", int'(vtrip), 4);
    chk("busy_mid_scan", int'(busy), 1);
    e = model(8, -1);
    do_start();
    e.st_cyc = cyc;
    e.brun   = -1;
    sb.push_back(e);
    chk("restart_ena_stays", int'(ena), 1);
    chk("restart_valid_low", int'(margin_valid), 0);
    wait_done();

    // stop + start together in MONITOR: stop wins
    start = 1'b1; stop = 1'b1;
    tick(1);
    start = 1'b0; stop = 1'b0;
    chk("stopstart_ena", int'(ena), 0);
    chk("stopstart_busy", int'(busy), 0);
    chk("stopstart_valid", int'(margin_valid), 0);
    chk("stopstart_margin", int'(margin_code), 0);
    chk("stopstart_vtrip", int'(vtrip), 0);
    tick(2);
    chk("stopstart_all_low", int'(outs), 0);

    // stop mid-scan
    do_start();
    tick(30);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    chk("stop_mid_scan_busy", int'(busy), 0);
    chk("stop_mid_scan_ena", int'(ena), 0);

    // rst during SAMPLE of code 1
    do_start();
    tick(S + P + ST + 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_sample_outputs", int'(outs), 0);
    tick(2);
    rst = 1'b0;
    tick(5);
    chk("after_rst_outputs", int'(outs), 0);
    run_scan(3, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
